// File: rtl/alu_pkg.sv
// Shared ALU constants: FSM encodings, add/sub mode codes and a counter width helper.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_bits(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-wide ripple of 1-bit adder or true-borrow subtractor cells.
module addsub_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic c;

  // In subtract mode c carries a borrow, so no operand inversion is needed.
  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      if (mode == MODE_SUB) c = (~a[i] & b[i]) | (c & ~(a[i] ^ b[i]));
      else                  c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor with start/busy/done handshake.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_bits(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             mode_r, c_r, sign_a, sign_b;

  logic [DIGIT-1:0]       dig_s;
  logic                   dig_c;
  logic [WIDTH+DIGIT-1:0] shifted;
  logic [WIDTH-1:0]       res_next, res_final;
  logic                   ovf_next;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .cin  (c_r),
    .mode (mode_r),
    .s    (dig_s),
    .cout (dig_c)
  );

  // Operand signs are latched at start because the shifters consume the MSBs.
  always_comb begin
    shifted  = {dig_s, res_sr};
    res_next = shifted[WIDTH+DIGIT-1:DIGIT];
    if (mode_r == MODE_ADD) ovf_next = (sign_a == sign_b) && (res_next[WIDTH-1] != sign_a);
    else                    ovf_next = (sign_a != sign_b) && (res_next[WIDTH-1] != sign_a);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_next) res_final = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else          res_final = res_next;
`else
    res_final = res_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      mode_r   <= MODE_ADD;
      c_r      <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            mode_r <= mode;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            c_r    <= 1'b0;
            cnt    <= '0;
            state  <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          c_r    <= dig_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            result   <= res_final;
            carry    <= dig_c;
            overflow <= ovf_next;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign zero = (result == '0);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: one DIGIT=1 and one DIGIT=4 instance, WIDTH=8.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, start1, mode1;
  logic [7:0] a1, b1;
  logic       busy1, done1, carry1, ovf1, zero1;
  logic [7:0] result1;

  logic       rst4_n, start4, mode4;
  logic [7:0] a4, b4;
  logic       busy4, done4, carry4, ovf4, zero4;
  logic [7:0] result4;

  exp_t q1[$], q4[$];
  exp_t e1, e4;
  int   cycle = 0;
  int   n_vec = 0, n_err = 0;

  always @(posedge clk) cycle <= cycle + 1;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry(carry1),
    .overflow(ovf1), .zero(zero1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .carry(carry4),
    .overflow(ovf4), .zero(zero4)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per done pulse, independent of the stimulus.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        check_output("d1 unexpected done", done1, 1'b0);
      end else begin
        e1 = q1.pop_front();
        check_output("d1 result", result1, e1.res);
        check_output("d1 carry", carry1, e1.carry);
        check_output("d1 overflow", ovf1, e1.ovf);
        check_output("d1 zero", zero1, e1.zero);
        check_output("d1 done cycle", cycle, e1.done_cyc);
        check_output("d1 busy at done", busy1, 1'b0);
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        check_output("d4 unexpected done", done4, 1'b0);
      end else begin
        e4 = q4.pop_front();
        check_output("d4 result", result4, e4.res);
        check_output("d4 carry", carry4, e4.carry);
        check_output("d4 overflow", ovf4, e4.ovf);
        check_output("d4 zero", zero4, e4.zero);
        check_output("d4 done cycle", cycle, e4.done_cyc);
      end
    end
  end

  // Issue one op on the DIGIT=1 instance; optionally pulse a stray start mid-RUN.
  task automatic apply_stimulus1(input string tag, input logic m, input logic [7:0] a, b,
                                 input logic [7:0] r, input logic c, o, z, input bit inject);
    exp_t e;
    int   bc, t;
    e.res = r; e.carry = c; e.ovf = o; e.zero = z;
    e.done_cyc = cycle + 1 + 8;
    q1.push_back(e);
    start1 = 1'b1; mode1 = m; a1 = a; b1 = b;
    @(negedge clk);
    start1 = 1'b0; mode1 = ~m; a1 = ~a; b1 = ~b;
    bc = 0; t = 0;
    while (!done1 && t < 30) begin
      if (busy1) bc++;
      @(negedge clk);
      t++;
      if (inject && t == 3) begin
        start1 = 1'b1; mode1 = 1'b0; a1 = 8'hFF; b1 = 8'hFF;
      end else begin
        start1 = 1'b0;
      end
    end
    check_output({tag, " done seen"}, done1, 1'b1);
    check_output({tag, " busy cycles"}, bc, 8);
    @(negedge clk);
  endtask

  task automatic wait_done4(input string tag);
    int t;
    t = 0;
    while (!done4 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_output({tag, " done seen"}, done4, 1'b1);
  endtask

  initial begin
    rst1_n = 1'b0; start1 = 1'b0; mode1 = 1'b0; a1 = '0; b1 = '0;
    rst4_n = 1'b0; start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    check_output("reset result", result1, 8'h00);
    check_output("reset carry", carry1, 1'b0);
    check_output("reset overflow", ovf1, 1'b0);
    check_output("reset zero", zero1, 1'b1);
    check_output("reset busy", busy1, 1'b0);
    check_output("reset done", done1, 1'b0);
    check_output("reset d4 zero", zero4, 1'b1);
    rst1_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);

    apply_stimulus1("sub 11-7",   1'b1, 8'd11,  8'd7,   8'h04, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus1("sub 8-21",   1'b1, 8'd8,   8'd21,  8'hF3, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus1("sub 1-1",    1'b1, 8'd1,   8'd1,   8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus1("add 200+100",1'b0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_ADDSUB_SAT_EN
    apply_stimulus1("add 7F+01",  1'b0, 8'h7F,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    apply_stimulus1("add 7F+01",  1'b0, 8'h7F,  8'h01,  8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    apply_stimulus1("stray start",1'b0, 8'h10,  8'h05,  8'h15, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    check_output("stray start queue", q1.size(), 0);

    // Abort an operation in its fourth RUN cycle.
    start1 = 1'b1; mode1 = 1'b0; a1 = 8'h33; b1 = 8'h44;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst1_n = 1'b0;
    #1;
    check_output("abort result", result1, 8'h00);
    check_output("abort carry", carry1, 1'b0);
    check_output("abort overflow", ovf1, 1'b0);
    check_output("abort zero", zero1, 1'b1);
    check_output("abort busy", busy1, 1'b0);
    check_output("abort done", done1, 1'b0);
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_output("post-abort done", done1, 1'b0);
    end
`ifdef SERIAL_ADDSUB_SAT_EN
    apply_stimulus1("sub 80-01",  1'b1, 8'h80,  8'h01,  8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    apply_stimulus1("sub 80-01",  1'b1, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // DIGIT=4: single op, then a back-to-back op issued in the DONE cycle.
    e4.res = 8'h0C; e4.carry = 1'b0; e4.ovf = 1'b0; e4.zero = 1'b0;
    e4.done_cyc = cycle + 1 + 2;
    q4.push_back(e4);
    start4 = 1'b1; mode4 = 1'b1; a4 = 8'h19; b4 = 8'h0D;
    @(negedge clk);
    start4 = 1'b0; a4 = 8'hAA; b4 = 8'h55;
    wait_done4("d4 sub 19-0D");
    e4.res = 8'h08; e4.carry = 1'b0; e4.ovf = 1'b0; e4.zero = 1'b0;
    e4.done_cyc = cycle + 1 + 2;
    q4.push_back(e4);
    start4 = 1'b1; mode4 = 1'b0; a4 = 8'h05; b4 = 8'h03;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4("d4 add 05+03");

    repeat (5) @(negedge clk);
    check_output("d1 queue drained", q1.size(), 0);
    check_output("d4 queue drained", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
